// File: rtl/wb_data_ram_pkg.sv
// Shared definitions for the Wishbone slave family: bus FSM states,
// reset levels and the all-zero data word.
package wb_data_ram_pkg;

   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_WAIT = 2'd1,
      WB_RESP = 2'd2
   } wb_state_e;

   localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
   localparam logic        RST_ENABLE  = 1'b0;
   localparam logic        RST_DISABLE = 1'b1;

endpackage

// File: rtl/wb_data_ram_if.sv
// Wishbone classic data-bus signals between the core's data master and
// a memory slave.
interface wb_data_ram_if;

   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [31:0] wb_adr_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );

endinterface

// File: rtl/wb_ram_bytelane.sv
// One byte lane of the data memory: synchronous write, asynchronous read.
// Four of these side by side form the 32-bit word store.
module wb_ram_bytelane #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [7:0]            din,
   output logic [7:0]            dout
);

   logic [7:0] mem [2**ADDR_WIDTH];

   // Store the byte on the clock edge when this lane is enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
   end

   assign dout = mem[addr];

endmodule

// File: rtl/wb_data_ram.sv
// Wishbone classic data memory slave with programmable wait states.
// A request is latched in IDLE, optionally delayed in WAIT, and answered
// for one cycle in RESP with ack (good access) or err (bad address/sel).
module wb_data_ram
   import wb_data_ram_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 10,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   wb_data_ram_if.slave  bus
);

   localparam int TAG_LSB = ADDR_WIDTH + 2;

   wb_state_e             state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic                  we_q;
   logic [3:0]            sel_q;
   logic [31:0]           dat_q;
   logic                  bad_q;
   logic                  req;
   logic                  addr_good;
   logic                  commit;
   logic [3:0]            lane_we;
   logic [31:0]           rd_word;

   assign req       = bus.wb_cyc_i & bus.wb_stb_i;
   assign addr_good = (bus.wb_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) &&
                      (bus.wb_adr_i[1:0] == 2'b00) &&
                      (bus.wb_sel_i != 4'b0000);

   // State and wait counter; reset drops any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state <= WB_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Capture the request fields when IDLE accepts a new cycle.
   always_ff @(posedge clk) begin
      if (state == WB_IDLE && req) begin
         idx_q <= bus.wb_adr_i[TAG_LSB-1:2];
         we_q  <= bus.wb_we_i;
         sel_q <= bus.wb_sel_i;
         dat_q <= bus.wb_dat_i;
         bad_q <= ~addr_good;
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, one cycle of RESP.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         WB_IDLE: begin
            if (req) begin
               cnt_nxt   = 4'(WAIT_STATES);
               state_nxt = (WAIT_STATES > 0) ? WB_WAIT : WB_RESP;
            end
         end
         WB_WAIT: begin
            if (!bus.wb_cyc_i) begin
               state_nxt = WB_IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state_nxt = WB_RESP;
               end
            end
         end
         WB_RESP: state_nxt = WB_IDLE;
         default: state_nxt = WB_IDLE;
      endcase
   end

   // A good write lands on the edge leaving RESP, unless reset hits that edge.
   assign commit  = (state == WB_RESP) && !bad_q && we_q && (rst == RST_DISABLE);
   assign lane_we = {4{commit}} & sel_q;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      wb_ram_bytelane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
         .clk  (clk),
         .we   (lane_we[g]),
         .addr (idx_q),
         .din  (dat_q[8*g +: 8]),
         .dout (rd_word[8*g +: 8])
      );
   end

   // Responses derive only from registered state; the stored word is read
   // straight from the array so a write committed one edge earlier is seen.
   assign bus.wb_ack_o = (state == WB_RESP) && !bad_q;
   assign bus.wb_err_o = (state == WB_RESP) &&  bad_q;
   assign bus.wb_dat_o = bus.wb_ack_o ? rd_word : ZERO_WORD;

endmodule

// File: tb/tb_wb_data_ram.sv
// Scoreboard bench for wb_data_ram: three instances with 1, 3 and 0 wait
// states share one stimulus bus, enabled one at a time.
module tb_wb_data_ram;

   logic        clk;
   logic        rst;
   logic        cyc, stb, we;
   logic [31:0] adr, dat;
   logic [3:0]  sel;
   logic [2:0]  en;
   int          cyc_cnt;
   int          checks;
   int          failures;
   bit          mon_on;

   typedef struct {
      int          id;
      bit          is_err;
      bit          chk;
      logic [31:0] dat;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   logic        ack_a [3];
   logic        err_a [3];
   logic [31:0] dat_a [3];

   wb_data_ram_if bus0 ();
   wb_data_ram_if bus1 ();
   wb_data_ram_if bus2 ();

   assign bus0.wb_cyc_i = cyc & en[0];
   assign bus0.wb_stb_i = stb & en[0];
   assign bus0.wb_we_i  = we;
   assign bus0.wb_adr_i = adr;
   assign bus0.wb_sel_i = sel;
   assign bus0.wb_dat_i = dat;
   assign bus1.wb_cyc_i = cyc & en[1];
   assign bus1.wb_stb_i = stb & en[1];
   assign bus1.wb_we_i  = we;
   assign bus1.wb_adr_i = adr;
   assign bus1.wb_sel_i = sel;
   assign bus1.wb_dat_i = dat;
   assign bus2.wb_cyc_i = cyc & en[2];
   assign bus2.wb_stb_i = stb & en[2];
   assign bus2.wb_we_i  = we;
   assign bus2.wb_adr_i = adr;
   assign bus2.wb_sel_i = sel;
   assign bus2.wb_dat_i = dat;

   assign ack_a[0] = bus0.wb_ack_o;
   assign err_a[0] = bus0.wb_err_o;
   assign dat_a[0] = bus0.wb_dat_o;
   assign ack_a[1] = bus1.wb_ack_o;
   assign err_a[1] = bus1.wb_err_o;
   assign dat_a[1] = bus1.wb_dat_o;
   assign ack_a[2] = bus2.wb_ack_o;
   assign err_a[2] = bus2.wb_err_o;
   assign dat_a[2] = bus2.wb_dat_o;

   wb_data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_ws1 (
      .clk (clk), .rst (rst), .bus (bus0)
   );
   wb_data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
      .clk (clk), .rst (rst), .bus (bus1)
   );
   wb_data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
      .clk (clk), .rst (rst), .bus (bus2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic int ws_of(input int id);
      case (id)
         0:       return 1;
         1:       return 3;
         default: return 0;
      endcase
   endfunction

   // Monitor: pop the scoreboard whenever a slave terminates a cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on) begin
            for (int k = 0; k < 3; k++) begin
               if (ack_a[k] && err_a[k]) begin
                  failures++;
                  $display("FAIL ack_err_both dut=%0d actual ack=1 err=1 required not both", k);
               end
               if (ack_a[k] || err_a[k]) begin
                  checks++;
                  if (sb.size() == 0) begin
                     failures++;
                     $display("FAIL unexpected_resp dut=%0d cycle=%0d actual ack=%0b err=%0b required none",
                              k, cyc_cnt, ack_a[k], err_a[k]);
                  end else begin
                     exp_t e;
                     logic [31:0] want;
                     e = sb.pop_front();
                     want = e.is_err ? 32'h0 : e.dat;
                     if (e.id != k || e.is_err != err_a[k] || e.cyc != cyc_cnt ||
                         ((e.is_err || e.chk) && dat_a[k] !== want)) begin
                        failures++;
                        $display("FAIL resp dut=%0d actual err=%0b dat=%h cycle=%0d required dut=%0d err=%0b dat=%h cycle=%0d",
                                 k, err_a[k], dat_a[k], cyc_cnt, e.id, e.is_err, want, e.cyc);
                     end
                  end
               end else begin
                  checks++;
                  if (dat_a[k] !== 32'h0) begin
                     failures++;
                     $display("FAIL idle_dat dut=%0d actual %h required 00000000", k, dat_a[k]);
                  end
               end
            end
         end
      end
   end

   task automatic xfer(input int id, input bit w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       input bit exp_err, input bit chk, input logic [31:0] exp_d);
      exp_t e;
      bit   got;
      @(negedge clk);
      en  = 3'(1 << id);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
      @(posedge clk);
      #1;
      e.id = id; e.is_err = exp_err; e.chk = chk; e.dat = exp_d;
      e.cyc = cyc_cnt + ws_of(id);
      sb.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (ack_a[id] || err_a[id]) got = 1'b1;
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL timeout dut=%0d adr=%h actual no response required ack/err", id, a);
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic check_quiet(input int id, input string name);
      checks++;
      if (ack_a[id] !== 1'b0 || err_a[id] !== 1'b0 || dat_a[id] !== 32'h0) begin
         failures++;
         $display("FAIL %s dut=%0d actual ack=%0b err=%0b dat=%h required 0 0 00000000",
                  name, id, ack_a[id], err_a[id], dat_a[id]);
      end
   endtask

   logic [31:0] b2b_dat [4];

   initial begin
      cyc_cnt = 0; checks = 0; failures = 0; mon_on = 1'b0;
      rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      adr = 32'h0; sel = 4'h0; dat = 32'h0; en = 3'b000;
      b2b_dat[0] = 32'h0102_0304; b2b_dat[1] = 32'hA5A5_5A5A;
      b2b_dat[2] = 32'hFFFF_FFFF; b2b_dat[3] = 32'h8000_0001;

      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) check_quiet(k, "reset_outputs");
      @(negedge clk);
      rst = 1'b1;
      mon_on = 1'b1;

      // Full-word write/read, byte lane update, errors (1 wait state)
      xfer(0, 1, 32'h10, 4'b1111, 32'hDEAD_BEEF, 0, 0, 32'h0);
      xfer(0, 0, 32'h10, 4'b1111, 32'h0,         0, 1, 32'hDEAD_BEEF);
      xfer(0, 1, 32'h10, 4'b0100, 32'h00AA_0000, 0, 0, 32'h0);
      xfer(0, 0, 32'h10, 4'b0001, 32'h0,         0, 1, 32'hDEAA_BEEF);
      xfer(0, 0, 32'h1000, 4'b1111, 32'h0,       1, 0, 32'h0);
      xfer(0, 1, 32'h11, 4'b1111, 32'h1234_5678, 1, 0, 32'h0);
      xfer(0, 1, 32'h10, 4'b0000, 32'h1234_5678, 1, 0, 32'h0);
      xfer(0, 0, 32'h10, 4'b1111, 32'h0,         0, 1, 32'hDEAA_BEEF);
      xfer(0, 1, 32'hFFC, 4'b1111, 32'hCAFE_F00D, 0, 0, 32'h0);
      xfer(0, 0, 32'hFFC, 4'b1111, 32'h0,         0, 1, 32'hCAFE_F00D);

      // Abort during WAIT (3 wait states)
      xfer(1, 1, 32'h20, 4'b1111, 32'h1122_3344, 0, 0, 32'h0);
      @(negedge clk);
      en = 3'b010; cyc = 1'b1; stb = 1'b1; we = 1'b1;
      adr = 32'h20; sel = 4'b1111; dat = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      repeat (8) @(negedge clk);
      xfer(1, 0, 32'h20, 4'b1111, 32'h0, 0, 1, 32'h1122_3344);

      // Reset while a write sits in WAIT
      @(negedge clk);
      en = 3'b010; cyc = 1'b1; stb = 1'b1; we = 1'b1;
      adr = 32'h20; sel = 4'b1111; dat = 32'h5555_5555;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_quiet(1, "reset_mid_op");
      @(negedge clk);
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      repeat (6) @(negedge clk);
      xfer(1, 0, 32'h20, 4'b1111, 32'h0, 0, 1, 32'h1122_3344);

      // Back-to-back reads with stb held (0 wait states)
      for (int i = 0; i < 4; i++) begin
         xfer(2, 1, 32'(4 * i), 4'b1111, b2b_dat[i], 0, 0, 32'h0);
      end
      @(negedge clk);
      en = 3'b100; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'b1111; adr = 32'h0;
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         @(posedge clk);
         #1;
         e.id = 2; e.is_err = 1'b0; e.chk = 1'b1; e.dat = b2b_dat[i]; e.cyc = cyc_cnt;
         sb.push_back(e);
         @(negedge clk);
         if (i < 3) begin
            adr = 32'(4 * (i + 1));
            @(posedge clk);
         end else begin
            cyc = 1'b0; stb = 1'b0;
         end
      end

      repeat (6) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL pending_resp actual %0d outstanding required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual running required finished");
      $fatal(1, "bench time limit reached");
   end

endmodule

// File: doc/wb_data_ram.md
Name: wb_data_ram

Overview:
- Wishbone-classic slave data memory: the responder end of the CPU data-bus initiator in the minimal SOPC.
- Accepts single word/byte/halfword load-store cycles from the core's data master.
- Answers with ack (or err) after a programmable number of wait states.
- Lets the core's stall logic be exercised.
- Instantiated beside the instruction ROM inside the SOPC top level.

Parameters:
- ADDR_WIDTH, 10: word-address bits; depth = 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1: extra cycles inserted before ack; range 0..15.
- BASE_ADDR, 32'h0000_0000: byte base address; must be aligned to 4*2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- wb_cyc_i  in  1  bus cycle active.
- wb_stb_i  in  1  strobe, request valid.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  32  byte address.
- wb_sel_i  in  4  byte lane selects, big-endian: sel[3] -> dat[31:24], sel[0] -> dat[7:0].
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid only while wb_ack_o = 1.
- wb_ack_o  out  1  normal termination, one-cycle pulse.
- wb_err_o  out  1  error termination, one-cycle pulse.

Behaviour:
- Reset (rst = 0 at a clock edge):
  - State goes to IDLE; wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0, wait counter = 0.
  - Memory array is not cleared.
  - Reset during WAIT or RESP drops the transaction with no write and no ack.
- States:
  - IDLE: on an edge where cyc & stb = 1, latch adr, we, sel, dat_i.
    - Address check: adr[31:ADDR_WIDTH+2] must equal BASE_ADDR[31:ADDR_WIDTH+2], adr[1:0] must be 0, and sel must be nonzero. Failure sets a bad flag.
    - Counter <= WAIT_STATES.
    - Next state: WAIT if WAIT_STATES > 0, else RESP.
  - WAIT: decrement the counter each cycle; move to RESP when the counter reaches 1. If cyc = 0 at any edge -> IDLE (abort: no write, no ack).
  - RESP: outputs for exactly one cycle.
    - Good: wb_ack_o = 1. A write updates only the selected byte lanes at the latched word index (adr[ADDR_WIDTH+1:2]), committed on the edge leaving RESP. A read drives the full stored word on wb_dat_o, regardless of sel.
    - Bad: wb_err_o = 1, wb_dat_o = 0, no write.
    - Always -> IDLE.
- Latency: ack/err is high WAIT_STATES+1 cycles after the accepting edge. With WAIT_STATES = 0, ack is in the cycle right after the request is sampled.
- Outputs are registered. ack and err are never both 1. Outside RESP, wb_dat_o = 0 and ack = err = 0.
- Back-to-back: IDLE samples again on the edge after RESP.
  - If the master still holds stb then, a new transaction starts.
  - The master must drop or renew stb in the ack cycle, per classic Wishbone.
- Inputs are ignored outside IDLE, except that cyc is monitored for abort in WAIT.
- A read in the cycle after a write to the same word returns the new data.

Decomposition:
- Shared defines file: WB state encodings, ZeroWord, and the RstEnable (1'b0) / RstDisable macros. These are used by all Wishbone slaves.
- One natural sub-module: wb_ram_bytelane, a 2^ADDR_WIDTH x 8 synchronous-write array, instantiated four times, one per sel bit.
- The FSM stays in the top.

Test Plan:
1. WAIT_STATES = 1: write adr 0x0000_0010, sel 4'b1111, dat 0xDEADBEEF, then read 0x10 -> ack 2 cycles after each accept; read dat_o = 0xDEADBEEF; err stays 0.
2. Byte lanes: after test 1, write 0x10 with sel 4'b0100 and dat 0x00AA0000, then read -> 0xDEAABEEF.
3. Error: read 0x0000_1000 (ADDR_WIDTH 10, out of range) -> err pulse 1 cycle, ack 0, dat_o 0. Write to 0x0000_0011 (misaligned) -> err, and a later read of 0x10 is unchanged.
4. Abort: with WAIT_STATES = 3, start a write to 0x20, drop cyc 1 cycle later -> no ack/err; read 0x20 returns the prior contents.
5. Reset mid-op: pull rst low during the WAIT of a write -> outputs 0 the next cycle, no write committed; after release, a normal read works.
6. Back-to-back with WAIT_STATES = 0: stb held across 4 consecutive reads of 0x0, 0x4, 0x8, 0xC -> ack every other cycle with the correct data in order.
